// File: rtl/pipe_sched_pkg.sv
// Shared opcode map, FSM encoding and source/destination decode for the
// pipeline issue scheduler.
package pipe_sched_pkg;

    localparam int CODE_W = 6;

    localparam logic [CODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [CODE_W-1:0] OP_ADDI  = 6'h01;
    localparam logic [CODE_W-1:0] OP_LW    = 6'h02;
    localparam logic [CODE_W-1:0] OP_SW    = 6'h03;
    localparam logic [CODE_W-1:0] OP_NOP   = 6'h3E;
    localparam logic [CODE_W-1:0] OP_HALT  = 6'h3F;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    typedef struct packed {
        logic uses_i;
        logic uses_j;
        logic uses_k;
        logic writes_i;
    } reg_use_t;

    // Unlisted opcodes fall into the default arm and behave as NOP.
    function automatic reg_use_t src_dst_decode(input logic [CODE_W-1:0] i_code);
        reg_use_t use_s;
        case (i_code)
            OP_RTYPE:       use_s = 4'b0111;
            OP_ADDI, OP_LW: use_s = 4'b0101;
            OP_SW:          use_s = 4'b1100;
            default:        use_s = 4'b0000;
        endcase
        return use_s;
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Shift-register scoreboard of destinations in flight in stages 1-4, with the
// read-after-write compare against stages 1-3.
module pipe_scoreboard
    import pipe_sched_pkg::*;
#(
    parameter int REG_SIZE = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_v,
    input  logic [REG_SIZE-1:0] push_r,
    input  logic [REG_SIZE-1:0] src_i,
    input  logic [REG_SIZE-1:0] src_j,
    input  logic [REG_SIZE-1:0] src_k,
    input  logic                use_i,
    input  logic                use_j,
    input  logic                use_k,
    output logic                hazard,
    output logic                empty
);

    logic [4:1]          sb_v_r;
    logic [REG_SIZE-1:0] sb_r_r [1:4];
    logic                hit_i_s;
    logic                hit_j_s;
    logic                hit_k_s;

    // Stages 1-4 never stall, so the scoreboard shifts on every clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_v_r <= 4'b0000;
            for (int k = 1; k <= 4; k++) begin
                sb_r_r[k] <= {REG_SIZE{1'b0}};
            end
        end else begin
            sb_v_r    <= {sb_v_r[3:1], push_v};
            sb_r_r[1] <= push_r;
            for (int k = 2; k <= 4; k++) begin
                sb_r_r[k] <= sb_r_r[k-1];
            end
        end
    end

    // Stage 4 is left out: its register-file write lands before the stage-1 read.
    always_comb begin
        hit_i_s = 1'b0;
        hit_j_s = 1'b0;
        hit_k_s = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (sb_v_r[k]) begin
                hit_i_s = hit_i_s | (sb_r_r[k] == src_i);
                hit_j_s = hit_j_s | (sb_r_r[k] == src_j);
                hit_k_s = hit_k_s | (sb_r_r[k] == src_k);
            end else begin
                hit_i_s = hit_i_s;
                hit_j_s = hit_j_s;
                hit_k_s = hit_k_s;
            end
        end
        hazard = (use_i && (src_i != {REG_SIZE{1'b0}}) && hit_i_s)
              || (use_j && (src_j != {REG_SIZE{1'b0}}) && hit_j_s)
              || (use_k && (src_k != {REG_SIZE{1'b0}}) && hit_k_s);
        empty  = ~|sb_v_r;
    end

endmodule

// File: rtl/pipe_hazard_sched.sv
// Issue scheduler for the 5-stage pipeline: PC/ID_Reg enables, RAW bubbles,
// start/halt/drain sequencing and bring-up counters.
module pipe_hazard_sched
    import pipe_sched_pkg::*;
#(
    parameter int CODE_SIZE = 6,
    parameter int REG_SIZE  = 5,
    parameter int CNT_SIZE  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CODE_SIZE-1:0] i_code_0,
    input  logic [REG_SIZE-1:0]  r_i_0,
    input  logic [REG_SIZE-1:0]  r_j_0,
    input  logic [REG_SIZE-1:0]  r_k_0,
    output logic                 p_enable,
    output logic                 i_enable,
    output logic                 bubble,
    output logic                 done,
    output logic [CNT_SIZE-1:0]  stall_cnt,
    output logic [CNT_SIZE-1:0]  instr_cnt
);

    logic [1:0]          state_r;
    logic [1:0]          state_nxt_s;
    logic                armed_r;
    logic [CODE_W-1:0]   code_s;
    reg_use_t            use_s;
    logic                is_halt_s;
    logic                hazard_s;
    logic                empty_s;
    logic                issue_s;
    logic                stall_inc_s;
    logic                push_v_s;
    logic [REG_SIZE-1:0] push_r_s;
    logic [CNT_SIZE-1:0] stall_cnt_r;
    logic [CNT_SIZE-1:0] instr_cnt_r;

    assign code_s      = CODE_W'(i_code_0);
    assign use_s       = src_dst_decode(code_s);
    assign is_halt_s   = (code_s == OP_HALT);
    assign issue_s     = (state_r == ST_RUN) && !hazard_s && !is_halt_s;
    assign stall_inc_s = (state_r == ST_RUN) && hazard_s && !is_halt_s;
    assign push_v_s    = issue_s && use_s.writes_i && (r_i_0 != {REG_SIZE{1'b0}});
    assign push_r_s    = push_v_s ? r_i_0 : {REG_SIZE{1'b0}};

    pipe_scoreboard #(
        .REG_SIZE (REG_SIZE)
    ) u_scoreboard (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_v (push_v_s),
        .push_r (push_r_s),
        .src_i  (r_i_0),
        .src_j  (r_j_0),
        .src_k  (r_k_0),
        .use_i  (use_s.uses_i),
        .use_j  (use_s.uses_j),
        .use_k  (use_s.uses_k),
        .hazard (hazard_s),
        .empty  (empty_s)
    );

    // Next-state logic; start is only honoured once a clock has passed since reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && armed_r) state_nxt_s = ST_RUN;
                else                  state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (is_halt_s) state_nxt_s = ST_DRAIN;
                else           state_nxt_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (empty_s) state_nxt_s = ST_HALTED;
                else         state_nxt_s = ST_DRAIN;
            end
            ST_HALTED: state_nxt_s = ST_HALTED;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and reset-release arming flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            armed_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            armed_r <= 1'b1;
        end
    end

    // Saturating stall and issue counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_SIZE{1'b0}};
            instr_cnt_r <= {CNT_SIZE{1'b0}};
        end else begin
            if (stall_inc_s && (stall_cnt_r != {CNT_SIZE{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_SIZE'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (issue_s && (instr_cnt_r != {CNT_SIZE{1'b1}})) begin
                instr_cnt_r <= instr_cnt_r + CNT_SIZE'(1);
            end else begin
                instr_cnt_r <= instr_cnt_r;
            end
        end
    end

    assign p_enable  = issue_s;
    assign bubble    = !issue_s;
    assign i_enable  = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    assign done      = (state_r == ST_HALTED);
    assign stall_cnt = stall_cnt_r;
    assign instr_cnt = instr_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Self-checking bench: directed programs plus random programs compared against
// a register-ready-time model of the issue rules.
module tb_pipe_hazard_sched;

    localparam logic [5:0] C_ADD  = 6'h00;
    localparam logic [5:0] C_ADDI = 6'h01;
    localparam logic [5:0] C_LW   = 6'h02;
    localparam logic [5:0] C_SW   = 6'h03;
    localparam logic [5:0] C_NOP  = 6'h3E;
    localparam logic [5:0] C_HALT = 6'h3F;

    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3;

    typedef struct {
        logic [5:0] c;
        logic [4:0] i;
        logic [4:0] j;
        logic [4:0] k;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  i_code_0;
    logic [4:0]  r_i_0, r_j_0, r_k_0;
    logic        p_enable, i_enable, bubble, done;
    logic [15:0] stall_cnt, instr_cnt;

    int tests = 0;
    int fails = 0;

    instr_t prog[$];
    int     pc;
    int     mst, cyc, last_w, m_stall, m_instr;
    int     ready[32];
    bit     armed_m;
    int     hold_cnt;

    always #5 clk = ~clk;

    pipe_hazard_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .i_code_0  (i_code_0),
        .r_i_0     (r_i_0),
        .r_j_0     (r_j_0),
        .r_k_0     (r_k_0),
        .p_enable  (p_enable),
        .i_enable  (i_enable),
        .bubble    (bubble),
        .done      (done),
        .stall_cnt (stall_cnt),
        .instr_cnt (instr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic instr_t cur_instr();
        instr_t h;
        h.c = C_HALT; h.i = 5'd0; h.j = 5'd0; h.k = 5'd0;
        if (pc < prog.size()) return prog[pc];
        return h;
    endfunction

    task automatic drive();
        instr_t x;
        x = cur_instr();
        i_code_0 = x.c; r_i_0 = x.i; r_j_0 = x.j; r_k_0 = x.k;
    endtask

    // Which fields an opcode reads and whether it writes field i.
    task automatic uses(input logic [5:0] c, output bit ri, output bit rj, output bit rk, output bit wi);
        ri = 0; rj = 0; rk = 0; wi = 0;
        if (c == C_ADD) begin rj = 1; rk = 1; wi = 1; end
        else if (c == C_ADDI || c == C_LW) begin rj = 1; wi = 1; end
        else if (c == C_SW) begin ri = 1; rj = 1; end
    endtask

    function automatic bit busy(input logic [4:0] r);
        return (r != 5'd0) && (cyc < ready[r]);
    endfunction

    // One clock: check outputs at the falling edge, then advance the model.
    task automatic step();
        instr_t x;
        bit ri, rj, rk, wi, haz, iss, is_halt;
        @(negedge clk);
        x = cur_instr();
        uses(x.c, ri, rj, rk, wi);
        is_halt = (x.c == C_HALT);
        haz = (ri && busy(x.i)) || (rj && busy(x.j)) || (rk && busy(x.k));
        iss = (mst == M_RUN) && !haz && !is_halt;
        chk("p_enable", 32'(p_enable), 32'(iss));
        chk("bubble",   32'(bubble),   32'(!iss));
        chk("i_enable", 32'(i_enable), 32'(mst == M_RUN || mst == M_DRAIN));
        chk("done",     32'(done),     32'(mst == M_HALT));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("instr_cnt", 32'(instr_cnt), 32'(m_instr));
        if (!done && i_enable && !p_enable) hold_cnt++;
        @(posedge clk);
        #1;
        if (mst == M_RUN && haz && !is_halt && m_stall < 65535) m_stall++;
        if (iss && m_instr < 65535) m_instr++;
        if (iss && wi && x.i != 5'd0) begin
            ready[x.i] = cyc + 4;
            last_w = cyc;
        end
        case (mst)
            M_IDLE:  if (start && armed_m) mst = M_RUN;
            M_RUN:   if (is_halt) mst = M_DRAIN;
            M_DRAIN: if (cyc > last_w + 4) mst = M_HALT;
            default: ;
        endcase
        armed_m = 1;
        cyc++;
        if (iss) pc++;
        drive();
    endtask

    // Asynchronous reset between edges; start is already high at release.
    task automatic reset_dut(input bit keep_pc);
        rst_n = 1'b0;
        #1;
        chk("rst_p_enable", 32'(p_enable), 32'd0);
        chk("rst_i_enable", 32'(i_enable), 32'd0);
        chk("rst_bubble",   32'(bubble),   32'd1);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_stall",    32'(stall_cnt), 32'd0);
        chk("rst_instr",    32'(instr_cnt), 32'd0);
        mst = M_IDLE; cyc = 0; last_w = -100; m_stall = 0; m_instr = 0;
        armed_m = 0; hold_cnt = 0;
        for (int r = 0; r < 32; r++) ready[r] = 0;
        if (!keep_pc) pc = 0;
        drive();
        start = 1'b1;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_to_halt(input int budget, input bit poke_start);
        int n = 0;
        int extra = 0;
        while (extra < 3 && n < budget) begin
            if (mst == M_IDLE) start = 1'b1;
            else if (poke_start) start = 1'($urandom_range(0, 1));
            else start = 1'b0;
            step();
            n++;
            if (mst == M_HALT) extra++;
        end
        chk("halt_reached", 32'(done), 32'd1);
    endtask

    function automatic instr_t mk(input logic [5:0] c, input int i, input int j, input int k);
        instr_t x;
        x.c = c; x.i = 5'(i); x.j = 5'(j); x.k = 5'(k);
        return x;
    endfunction

    initial begin
        instr_t x;
        rst_n = 1'b0; start = 1'b0; pc = 0;
        i_code_0 = C_NOP; r_i_0 = 5'd0; r_j_0 = 5'd0; r_k_0 = 5'd0;
        #6;

        // 1: independent stream
        prog = {mk(C_ADD,1,2,3), mk(C_ADD,4,5,6), mk(C_ADDI,7,8,5), mk(C_HALT,0,0,0)};
        reset_dut(0); run_to_halt(60, 0);
        chk("t1_stall", 32'(stall_cnt), 32'd0);
        chk("t1_instr", 32'(instr_cnt), 32'd3);

        // 2: back-to-back dependency
        prog = {mk(C_ADD,1,2,3), mk(C_ADD,4,1,5), mk(C_HALT,0,0,0)};
        reset_dut(0); run_to_halt(60, 0);
        chk("t2_stall", 32'(stall_cnt), 32'd3);
        chk("t2_instr", 32'(instr_cnt), 32'd2);

        // 3: distance 3 and distance 4 to SW
        prog = {mk(C_ADD,1,2,3), mk(C_NOP,0,0,0), mk(C_NOP,0,0,0), mk(C_SW,1,2,0), mk(C_HALT,0,0,0)};
        reset_dut(0); run_to_halt(60, 0);
        chk("t3a_stall", 32'(stall_cnt), 32'd1);
        prog = {mk(C_ADD,1,2,3), mk(C_NOP,0,0,0), mk(C_NOP,0,0,0), mk(C_NOP,0,0,0),
                mk(C_SW,1,2,0), mk(C_HALT,0,0,0)};
        reset_dut(0); run_to_halt(60, 0);
        chk("t3b_stall", 32'(stall_cnt), 32'd0);

        // 4: register 0 never creates a hazard
        prog = {mk(C_LW,0,1,0), mk(C_ADD,4,0,0), mk(C_HALT,0,0,0)};
        reset_dut(0); run_to_halt(60, 0);
        chk("t4_stall", 32'(stall_cnt), 32'd0);

        // 5: drain after a writer, then start is ignored once halted
        prog = {mk(C_ADD,9,1,2), mk(C_HALT,0,0,0)};
        reset_dut(0); run_to_halt(60, 0);
        chk("t5_hold_cycles", 32'(hold_cnt), 32'd5);
        for (int n = 0; n < 4; n++) begin
            start = 1'(n % 2);
            step();
        end
        chk("t5_done_kept", 32'(done), 32'd1);
        chk("t5_pc_held", 32'(p_enable), 32'd0);

        // 6: reset in the middle of a stall, then resume on the dependent instruction
        prog = {mk(C_ADD,1,2,3), mk(C_ADD,4,1,5), mk(C_HALT,0,0,0)};
        reset_dut(0);
        for (int n = 0; n < 4; n++) step();
        chk("t6_in_stall", 32'(stall_cnt), 32'd1);
        reset_dut(1);
        run_to_halt(60, 0);
        chk("t6_stall", 32'(stall_cnt), 32'd0);
        chk("t6_instr", 32'(instr_cnt), 32'd1);

        // Random programs over a small register set to provoke hazards
        for (int p = 0; p < 12; p++) begin
            int len;
            len = $urandom_range(10, 24);
            prog = {};
            for (int n = 0; n < len; n++) begin
                case ($urandom_range(0, 6))
                    0, 1:    x.c = C_ADD;
                    2:       x.c = C_ADDI;
                    3:       x.c = C_LW;
                    4:       x.c = C_SW;
                    5:       x.c = C_NOP;
                    default: x.c = 6'($urandom_range(4, 61));
                endcase
                x.i = 5'($urandom_range(0, 7));
                x.j = 5'($urandom_range(0, 7));
                x.k = 5'($urandom_range(0, 7));
                prog.push_back(x);
            end
            prog.push_back(mk(C_HALT,0,0,0));
            reset_dut(0);
            run_to_halt(5 * len + 40, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
